i2c_rx_ctrl: RTL and testbench
==============================

I2C_RX_CTRL -- requirements
Module: i2c_rx_ctrl

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'h71, giving the 7-bit address this slave acknowledges.
REQ-002 The block SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port rising_edge_found  input  1  one-cycle pulse per SCL rising edge, from the SCL edge detector.
REQ-005 The block SHALL have port falling_edge_found  input  1  one-cycle pulse per SCL falling edge.
REQ-006 The block SHALL have port start_found  input  1  one-cycle pulse on a START or repeated START.
REQ-007 The block SHALL have port stop_found  input  1  one-cycle pulse on a STOP.
REQ-008 The block SHALL have port sda_in  input  1  synchronized SDA level.
REQ-009 The block SHALL have port ack_drive  output  1  1 = pull SDA low (ACK); 0 = release.
REQ-010 The block SHALL have port rx_data  output  8  last complete data byte, MSB first on the wire.
REQ-011 The block SHALL have port byte_received  output  1  one-cycle pulse when rx_data updates.
REQ-012 The block SHALL have port addr_match  output  1  one-cycle pulse when the address byte matches.
REQ-013 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK and WAIT_STOP.
REQ-015 The block SHALL sample sda_in only in cycles with rising_edge_found=1, shifting into an 8-bit register MSB first and incrementing a 4-bit bit counter.
REQ-016 start_found SHALL force ADDR with the bit counter cleared and ack_drive=0 from any state, including a repeated START mid-byte.
REQ-017 stop_found SHALL force IDLE with ack_drive=0 from any state.
REQ-018 If start_found and stop_found are both high in one cycle, start_found SHALL win.
REQ-019 Rising and falling pulses SHALL be ignored in IDLE and WAIT_STOP.
REQ-020 If rising_edge_found and falling_edge_found are both high in one cycle, the falling pulse SHALL be ignored.
REQ-021 In ADDR, after the 8th sample, the block SHALL compare the shift register: match iff bits[7:1]==SLAVE_ADDR and bits[0] (R/W)==0; read requests SHALL NOT match.
REQ-022 On a match, addr_match SHALL pulse in the cycle after the 8th-sample cycle.
REQ-023 On a match, at the next falling_edge_found the FSM SHALL enter ADDR_ACK and ack_drive SHALL be 1 starting the following cycle.
REQ-024 On no match, the FSM SHALL go to WAIT_STOP at the next falling edge with ack_drive held at 0.
REQ-025 ADDR_ACK and DATA_ACK SHALL hold ack_drive=1 through the ACK-bit rising edge, which SHALL NOT be sampled.
REQ-026 At the next falling edge, ADDR_ACK and DATA_ACK SHALL release ack_drive and enter DATA with the bit counter cleared.
REQ-027 In DATA, the block SHALL load rx_data and pulse byte_received in the cycle after the 8th-sample cycle, then wait for a falling edge to enter DATA_ACK.
REQ-028 rx_data SHALL remain stable until the next byte completes, and SHALL NOT change on an aborted byte.
REQ-029 The latency from any input pulse to the corresponding registered output SHALL be exactly one clk cycle.

Reset
REQ-030 With rst=1 at a rising clk edge, the block SHALL enter IDLE with bit counter=0, shift register=0, rx_data=8'h00, and ack_drive, byte_received, addr_match and busy all 0.
REQ-031 A reset asserted mid-byte or during an ACK SHALL release ack_drive in the cycle following the reset edge.

Configuration
REQ-032 With macro I2C_GEN_CALL_EN defined, address byte 8'h00 (general call) SHALL also match and be ACKed exactly as SLAVE_ADDR.
REQ-033 With I2C_GEN_CALL_EN undefined, address byte 8'h00 SHALL be NACKed and the FSM SHALL go to WAIT_STOP.

Verification
REQ-034 Reset scenario: rst high 2 cycles -> all outputs 0, busy=0, rx_data=8'h00.
REQ-035 Write scenario: START, address 0xE2 (0x71, W), ACK clock, data 0xA5, ACK clock, STOP -> addr_match pulse and two ack_drive windows, each high from the falling edge after bit 8 to the next falling edge; byte_received pulse with rx_data=8'hA5; busy=0 after STOP.
REQ-036 Address mismatch scenario: START, address 0xE4 -> no addr_match, ack_drive stays 0; following byte 0x3C -> no byte_received and rx_data unchanged.
REQ-037 Read request scenario: START, address 0xE3 -> NACK and WAIT_STOP.
REQ-038 Repeated START scenario: repeated START after 4 data bits, then address 0xE2 and byte 0x0F -> clean restart, addr_match pulse, rx_data=8'h0F.
REQ-039 General call scenario: address 0x00 -> ACK with I2C_GEN_CALL_EN defined; NACK without it.

Source files
------------

// File: rtl/i2c_rx_ctrl.sv
// -----------------------------------------------------------------------------
// i2c_rx_ctrl
//
// Receive-side control FSM for a write-only I2C slave. The block sits behind
// an SCL edge detector and START/STOP detector. It shifts in the address
// byte, ACKs it when the address matches, and then receives data bytes
// MSB first, ACKing each one. It works only on one-cycle event pulses and the
// synchronized SDA level, so it runs entirely in the system clock domain.
//
// Parameters
//   SLAVE_ADDR          7-bit address acknowledged by this slave (default 7'h71)
//
// Optional feature
//   I2C_GEN_CALL_EN     when defined, the general-call address byte 8'h00 is
//                       also matched and ACKed. When undefined, 8'h00 is NACKed.
//
// Ports
//   clk                 system clock, all logic on the rising edge
//   rst                 synchronous active-high reset
//   rising_edge_found   one-cycle pulse per SCL rising edge (SDA sample point)
//   falling_edge_found  one-cycle pulse per SCL falling edge (SDA change point)
//   start_found         one-cycle pulse on START or repeated START
//   stop_found          one-cycle pulse on STOP
//   sda_in              synchronized SDA level
//   ack_drive           1 = pull SDA low to ACK, 0 = release
//   rx_data[7:0]        last complete data byte
//   byte_received       one-cycle pulse when rx_data updates
//   addr_match          one-cycle pulse when the address byte matches
//   busy                high in every state except IDLE
// -----------------------------------------------------------------------------
module i2c_rx_ctrl #(
    parameter logic [6:0] SLAVE_ADDR = 7'h71
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rising_edge_found,
    input  logic       falling_edge_found,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic       sda_in,
    output logic       ack_drive,
    output logic [7:0] rx_data,
    output logic       byte_received,
    output logic       addr_match,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        DATA      = 3'd3,
        DATA_ACK  = 3'd4,
        WAIT_STOP = 3'd5
    } state_t;

    state_t      state_q,         state_d;
    logic [3:0]  bit_cnt_q,       bit_cnt_d;
    logic [7:0]  shift_q,         shift_d;
    logic [7:0]  rx_data_q,       rx_data_d;
    logic        ack_q,           ack_d;
    logic        byte_rx_q,       byte_rx_d;
    logic        addr_match_q,    addr_match_d;

    // Event qualification. A falling pulse coincident with a rising pulse is
    // dropped so a single cycle can never both sample and advance past a bit.
    logic        rise_evt;
    logic        fall_evt;
    logic        byte_full;
    logic [7:0]  shift_in;

    assign rise_evt  = rising_edge_found;
    assign fall_evt  = falling_edge_found & ~rising_edge_found;
    assign byte_full = (bit_cnt_q == 4'd8);
    assign shift_in  = {shift_q[6:0], sda_in};

    // Address decode for a complete address byte. Only write requests match.
    function automatic logic addr_hit(input logic [7:0] addr_byte);
        logic hit;
        hit = (addr_byte[7:1] == SLAVE_ADDR) && (addr_byte[0] == 1'b0);
`ifdef I2C_GEN_CALL_EN
        hit = hit || (addr_byte == 8'h00);
`else
        hit = hit;
`endif
        return hit;
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'h00;
            rx_data_q    <= 8'h00;
            ack_q        <= 1'b0;
            byte_rx_q    <= 1'b0;
            addr_match_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            ack_q        <= ack_d;
            byte_rx_q    <= byte_rx_d;
            addr_match_q <= addr_match_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        ack_d        = ack_q;
        byte_rx_d    = 1'b0;
        addr_match_d = 1'b0;

        if (start_found) begin
            // START (or repeated START) restarts address reception from any
            // state and takes priority over a simultaneous STOP.
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            shift_d   = 8'h00;
            ack_d     = 1'b0;
        end else if (stop_found) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            ack_d     = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ack_d = 1'b0;
                end

                ADDR: begin
                    if (rise_evt && !byte_full) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // Decode on the incoming byte so the pulse lands in
                        // the cycle right after the 8th sample.
                        if (bit_cnt_q == 4'd7) begin
                            addr_match_d = addr_hit(shift_in);
                        end
                    end else if (fall_evt && byte_full) begin
                        if (addr_hit(shift_q)) begin
                            state_d = ADDR_ACK;
                            ack_d   = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                            ack_d   = 1'b0;
                        end
                    end
                end

                ADDR_ACK, DATA_ACK: begin
                    // The ACK-bit rising edge is deliberately not sampled; SDA
                    // is being driven by this block during that bit.
                    if (fall_evt) begin
                        state_d   = DATA;
                        bit_cnt_d = 4'd0;
                        ack_d     = 1'b0;
                    end
                end

                DATA: begin
                    if (rise_evt && !byte_full) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // rx_data only changes on a completed byte, so a byte
                        // cut short by START/STOP never disturbs it.
                        if (bit_cnt_q == 4'd7) begin
                            rx_data_d = shift_in;
                            byte_rx_d = 1'b1;
                        end
                    end else if (fall_evt && byte_full) begin
                        state_d = DATA_ACK;
                        ack_d   = 1'b1;
                    end
                end

                WAIT_STOP: begin
                    ack_d = 1'b0;
                end

                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = 4'd0;
                    ack_d     = 1'b0;
                end
            endcase
        end
    end

    assign ack_drive     = ack_q;
    assign rx_data       = rx_data_q;
    assign byte_received = byte_rx_q;
    assign addr_match    = addr_match_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_i2c_rx_ctrl
//
// Directed testbench for i2c_rx_ctrl. Drives one-cycle SCL/START/STOP event
// pulses and checks registered outputs one cycle later against hand-computed
// expectations. Prints one line per transaction and a single summary line.
// -----------------------------------------------------------------------------
module tb_i2c_rx_ctrl;

    logic       clk;
    logic       rst;
    logic       rising_edge_found;
    logic       falling_edge_found;
    logic       start_found;
    logic       stop_found;
    logic       sda_in;
    logic       ack_drive;
    logic [7:0] rx_data;
    logic       byte_received;
    logic       addr_match;
    logic       busy;

    int checks_cnt;
    int fail_cnt;

`ifdef I2C_GEN_CALL_EN
    localparam logic GC_EXPECT = 1'b1;
`else
    localparam logic GC_EXPECT = 1'b0;
`endif

    i2c_rx_ctrl #(.SLAVE_ADDR(7'h71)) dut (
        .clk                (clk),
        .rst                (rst),
        .rising_edge_found  (rising_edge_found),
        .falling_edge_found (falling_edge_found),
        .start_found        (start_found),
        .stop_found         (stop_found),
        .sda_in             (sda_in),
        .ack_drive          (ack_drive),
        .rx_data            (rx_data),
        .byte_received      (byte_received),
        .addr_match         (addr_match),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising clock edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rise(input logic b);
        sda_in            = b;
        rising_edge_found = 1'b1;
        tick();
        rising_edge_found = 1'b0;
    endtask

    task automatic pulse_fall();
        falling_edge_found = 1'b1;
        tick();
        falling_edge_found = 1'b0;
    endtask

    task automatic pulse_start();
        start_found = 1'b1;
        tick();
        start_found = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_found = 1'b1;
        tick();
        stop_found = 1'b0;
    endtask

    // Sends n bits MSB first. Returns right after the last rising pulse has
    // been registered, i.e. in the cycle following the final sample.
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            pulse_rise(b[i]);
            if (i != 8 - n) begin
                tick();
                pulse_fall();
                tick();
            end
        end
    endtask

    // ACK clock: master clock pulse while the slave may be holding SDA.
    task automatic ack_clock(input string tag, input logic exp_ack);
        pulse_rise(1'b1);
        check_eq({tag, "_ack_hold"}, 32'(ack_drive), 32'(exp_ack));
        tick();
        pulse_fall();
        check_eq({tag, "_ack_release"}, 32'(ack_drive), 32'h0);
    endtask

    initial begin
        checks_cnt         = 0;
        fail_cnt           = 0;
        rst                = 1'b1;
        rising_edge_found  = 1'b0;
        falling_edge_found = 1'b0;
        start_found        = 1'b0;
        stop_found         = 1'b0;
        sda_in             = 1'b1;

        // ---------------- Reset ----------------
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_ack",     32'(ack_drive),     32'h0);
        check_eq("rst_rx_data", 32'(rx_data),       32'h00);
        check_eq("rst_byte_rx", 32'(byte_received), 32'h0);
        check_eq("rst_match",   32'(addr_match),    32'h0);
        check_eq("rst_busy",    32'(busy),          32'h0);
        $display("txn reset: busy=%0b rx_data=0x%02h", busy, rx_data);

        // ---------------- Pulses ignored in IDLE ----------------
        send_bits(8'hFF, 8);
        check_eq("idle_byte_rx", 32'(byte_received), 32'h0);
        check_eq("idle_busy",    32'(busy),          32'h0);
        tick();
        $display("txn idle pulses: busy=%0b", busy);

        // ---------------- Write 0xE2 / 0xA5 ----------------
        pulse_start();
        check_eq("wr_start_busy", 32'(busy), 32'h1);
        send_bits(8'hE2, 8);
        check_eq("wr_addr_match",   32'(addr_match), 32'h1);
        check_eq("wr_ack_pre_fall", 32'(ack_drive),  32'h0);
        tick();
        check_eq("wr_match_1cyc",   32'(addr_match), 32'h0);
        pulse_fall();
        check_eq("wr_addr_ack_on",  32'(ack_drive),  32'h1);
        ack_clock("wr_addr", 1'b1);
        send_bits(8'hA5, 8);
        check_eq("wr_byte_rx",  32'(byte_received), 32'h1);
        check_eq("wr_rx_data",  32'(rx_data),       32'hA5);
        check_eq("wr_ack_off",  32'(ack_drive),     32'h0);
        tick();
        check_eq("wr_byte_rx_1cyc", 32'(byte_received), 32'h0);
        pulse_fall();
        check_eq("wr_data_ack_on", 32'(ack_drive), 32'h1);
        ack_clock("wr_data", 1'b1);
        pulse_stop();
        check_eq("wr_stop_busy", 32'(busy),      32'h0);
        check_eq("wr_stop_ack",  32'(ack_drive), 32'h0);
        $display("txn write: addr=0xE2 data=0x%02h busy=%0b", rx_data, busy);
        tick();

        // ---------------- Address mismatch 0xE4 ----------------
        pulse_start();
        send_bits(8'hE4, 8);
        check_eq("mm_match", 32'(addr_match), 32'h0);
        tick();
        pulse_fall();
        check_eq("mm_ack",  32'(ack_drive), 32'h0);
        check_eq("mm_busy", 32'(busy),      32'h1);
        ack_clock("mm", 1'b0);
        send_bits(8'h3C, 8);
        check_eq("mm_byte_rx", 32'(byte_received), 32'h0);
        check_eq("mm_rx_data", 32'(rx_data),       32'hA5);
        tick();
        pulse_stop();
        check_eq("mm_stop_busy", 32'(busy), 32'h0);
        $display("txn mismatch: addr=0xE4 rx_data=0x%02h", rx_data);
        tick();

        // ---------------- Read request 0xE3 ----------------
        pulse_start();
        send_bits(8'hE3, 8);
        check_eq("rd_match", 32'(addr_match), 32'h0);
        tick();
        pulse_fall();
        check_eq("rd_ack",  32'(ack_drive), 32'h0);
        check_eq("rd_busy", 32'(busy),      32'h1);
        pulse_stop();
        $display("txn read request: addr=0xE3 nack");
        tick();

        // ---------------- Repeated START mid-byte ----------------
        pulse_start();
        send_bits(8'hE2, 8);
        tick();
        pulse_fall();
        ack_clock("rs_first", 1'b1);
        send_bits(8'hB0, 4);
        tick();
        pulse_fall();
        tick();
        pulse_start();
        check_eq("rs_ack",     32'(ack_drive), 32'h0);
        check_eq("rs_busy",    32'(busy),      32'h1);
        check_eq("rs_rx_keep", 32'(rx_data),   32'hA5);
        send_bits(8'hE2, 8);
        check_eq("rs_match", 32'(addr_match), 32'h1);
        tick();
        // Coincident rise+fall: the fall is ignored, so no ACK yet.
        rising_edge_found  = 1'b1;
        falling_edge_found = 1'b1;
        tick();
        rising_edge_found  = 1'b0;
        falling_edge_found = 1'b0;
        check_eq("rs_both_edges_ack", 32'(ack_drive), 32'h0);
        pulse_fall();
        check_eq("rs_ack_on", 32'(ack_drive), 32'h1);
        ack_clock("rs_addr", 1'b1);
        send_bits(8'h0F, 8);
        check_eq("rs_byte_rx", 32'(byte_received), 32'h1);
        check_eq("rs_rx_data", 32'(rx_data),       32'h0F);
        tick();
        pulse_fall();
        ack_clock("rs_data", 1'b1);
        pulse_stop();
        $display("txn repeated start: addr=0xE2 data=0x%02h", rx_data);
        tick();

        // ---------------- General call 0x00 ----------------
        pulse_start();
        send_bits(8'h00, 8);
        check_eq("gc_match", 32'(addr_match), 32'(GC_EXPECT));
        tick();
        pulse_fall();
        check_eq("gc_ack",  32'(ack_drive), 32'(GC_EXPECT));
        check_eq("gc_busy", 32'(busy),      32'h1);
        pulse_stop();
        $display("txn general call: addr=0x00 ack=%0b", GC_EXPECT);
        tick();

        // ---------------- START and STOP together ----------------
        start_found = 1'b1;
        stop_found  = 1'b1;
        tick();
        start_found = 1'b0;
        stop_found  = 1'b0;
        check_eq("ss_start_wins", 32'(busy), 32'h1);
        pulse_stop();
        check_eq("ss_stop_busy", 32'(busy), 32'h0);
        $display("txn start+stop: start wins");

        // ---------------- Reset during ACK ----------------
        pulse_start();
        send_bits(8'hE2, 8);
        tick();
        pulse_fall();
        check_eq("rack_ack_before", 32'(ack_drive), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rack_ack_after", 32'(ack_drive), 32'h0);
        check_eq("rack_busy",      32'(busy),      32'h0);
        check_eq("rack_rx_data",   32'(rx_data),   32'h00);
        $display("txn reset during ack: ack=%0b busy=%0b", ack_drive, busy);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
